aes_round_ctrl: RTL and testbench

- Round sequencer for the AES-128 encryption datapath. It steps the datapath through the initial AddRoundKey, rounds 1-9 (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round 10, which omits MixColumns.
- Owns the round-key request handshake toward the key store and the enable/valid handshake toward the S-box.
- Emits one-cycle stage strobes consumed by the state-matrix datapath.

---
 rtl/aes_ctrl_pkg.sv | 35 +++
 rtl/aes_wait_timer.sv | 37 +++
 rtl/aes_round_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
//   aes_ctrl_state_e : sequencer FSM states
//   aes_ctrl_out_t   : registered control bundle driven toward the datapath,
//                      the key store and the S-box
package aes_ctrl_pkg;

  localparam int unsigned AES_NO_ROUNDS = 10;
  localparam int unsigned AES_KEY_SEL_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    KEY_WAIT = 3'd2,
    ARK      = 3'd3,
    SUB_WAIT = 3'd4,
    SHIFT    = 3'd5,
    MIX      = 3'd6,
    DONE     = 3'd7
  } aes_ctrl_state_e;

  // Control bundle registered as a unit so every output flops together.
  typedef struct packed {
    logic                     key_req;
    logic [AES_KEY_SEL_W-1:0] key_sel;
    logic                     sbox_en;
    logic                     load_en;
    logic                     ark_en;
    logic                     sub_en;
    logic                     shift_en;
    logic                     mix_en;
    logic                     busy;
    logic                     done;
  } aes_ctrl_out_t;

endpackage

// File: rtl/aes_wait_timer.sv
// Handshake wait-state timer for the AES round sequencer.
// Built only when AES_CTRL_TIMEOUT_EN is defined; otherwise this file
// contributes no logic.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (has priority over count)
//   count      : advance one step this cycle
//   expired_c  : combinational; high on the LIMIT-th counted cycle
`ifdef AES_CTRL_TIMEOUT_EN
module aes_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired_c
);

  // Count runs 0..LIMIT-1; the last value flags expiry.
  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = count && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: LOAD, initial AddRoundKey, rounds 1..NO_ROUNDS-1
// (Sub/Shift/Mix/ARK) and a final round without MixColumns.
// Optional macro AES_CTRL_TIMEOUT_EN adds a per-handshake wait timeout
// (parameter TIMEOUT_CYCLES) reported on a sticky err_o.
//   aes_clk, resetn    : clock, asynchronous active-low reset
//   aes_core_en        : core enable; low aborts to IDLE
//   start_i            : begin one block (IDLE only)
//   key_vld_i          : requested round key valid
//   sbox_valid_i       : S-box result valid
//   key_req_o/key_sel_o: round-key request and index
//   sbox_en_o          : S-box enable
//   load/ark/sub/shift/mix_en_o : one-cycle datapath strobes
//   round_o            : current round number
//   busy_o, done_o     : activity flag, one-cycle completion pulse
//   err_o              : sticky handshake timeout
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NO_ROUNDS = AES_NO_ROUNDS
`ifdef AES_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                     aes_clk,
  input  logic                     resetn,
  input  logic                     aes_core_en,
  input  logic                     start_i,
  input  logic                     key_vld_i,
  input  logic                     sbox_valid_i,
  output logic                     key_req_o,
  output logic [AES_KEY_SEL_W-1:0] key_sel_o,
  output logic                     sbox_en_o,
  output logic                     load_en_o,
  output logic                     ark_en_o,
  output logic                     sub_en_o,
  output logic                     shift_en_o,
  output logic                     mix_en_o,
  output logic [AES_KEY_SEL_W-1:0] round_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam logic [AES_KEY_SEL_W-1:0] LAST_ROUND = AES_KEY_SEL_W'(NO_ROUNDS);

  aes_ctrl_state_e            state_q, state_d;
  logic [AES_KEY_SEL_W-1:0]   round_q, round_d;
  aes_ctrl_out_t              out_q, out_d;

`ifdef AES_CTRL_TIMEOUT_EN
  logic err_q;
  logic err_set;
  logic wait_st;
  logic tmr_clear;
  logic tmr_expired_c;

  // Timer counts only while parked in a handshake state and restarts on
  // any state change, so each wait gets its own budget.
  assign wait_st   = (state_q == KEY_WAIT) || (state_q == SUB_WAIT);
  assign tmr_clear = (state_d != state_q);

  aes_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (aes_clk),
    .rst_n     (resetn),
    .clear     (tmr_clear),
    .count     (wait_st),
    .expired_c (tmr_expired_c)
  );
`endif

  // State, round counter and output bundle registers.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      round_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      out_q   <= out_d;
    end
  end

`ifdef AES_CTRL_TIMEOUT_EN
  // Sticky error; only reset clears it.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
`endif

  // Next state, round counter and output decode.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    out_d   = '0;
`ifdef AES_CTRL_TIMEOUT_EN
    err_set = 1'b0;
`endif

    if (!aes_core_en) begin
      // Abort overrides every other transition.
      state_d = IDLE;
      round_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD;
            round_d = '0;
          end
        end
        LOAD: state_d = KEY_WAIT;
        KEY_WAIT: begin
          if (key_vld_i) begin
            state_d = ARK;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tmr_expired_c) begin
            state_d = IDLE;
            err_set = 1'b1;
          end
`endif
        end
        ARK: begin
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + AES_KEY_SEL_W'(1);
            state_d = SUB_WAIT;
          end
        end
        SUB_WAIT: begin
          if (sbox_valid_i) begin
            state_d = SHIFT;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tmr_expired_c) begin
            state_d = IDLE;
            err_set = 1'b1;
          end
`endif
        end
        SHIFT: state_d = (round_q == LAST_ROUND) ? KEY_WAIT : MIX;
        MIX:   state_d = KEY_WAIT;
        DONE:  state_d = IDLE;
        default: begin
          state_d = IDLE;
          round_d = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the flopped bundle lines
    // up with the state it describes.
    out_d.busy = (state_d != IDLE);
    case (state_d)
      LOAD:     out_d.load_en = 1'b1;
      KEY_WAIT: begin
        out_d.key_req = 1'b1;
        out_d.key_sel = round_d;
      end
      ARK:      out_d.ark_en   = 1'b1;
      SUB_WAIT: out_d.sbox_en  = 1'b1;
      SHIFT:    out_d.shift_en = 1'b1;
      MIX:      out_d.mix_en   = 1'b1;
      DONE:     out_d.done     = 1'b1;
      default:  ;
    endcase
    // Capture pulse follows the cycle in which sbox_valid_i was accepted.
    out_d.sub_en = (state_q == SUB_WAIT) && (state_d == SHIFT);
  end

  assign key_req_o  = out_q.key_req;
  assign key_sel_o  = out_q.key_sel;
  assign sbox_en_o  = out_q.sbox_en;
  assign load_en_o  = out_q.load_en;
  assign ark_en_o   = out_q.ark_en;
  assign sub_en_o   = out_q.sub_en;
  assign shift_en_o = out_q.shift_en;
  assign mix_en_o   = out_q.mix_en;
  assign busy_o     = out_q.busy;
  assign done_o     = out_q.done;
  assign round_o    = round_q;

`ifdef AES_CTRL_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Expected done cycles and key_sel
// sequences are queued when a block is started and consumed when the DUT
// raises done_o / key_req_o. Timeout scenario requires AES_CTRL_TIMEOUT_EN.
module tb_aes_round_ctrl;

  logic       aes_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       aes_core_en = 1'b0;
  logic       start_i = 1'b0;
  logic       key_vld_i = 1'b0;
  logic       sbox_valid_i = 1'b0;
  logic       key_req_o;
  logic [3:0] key_sel_o;
  logic       sbox_en_o, load_en_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o;
  logic [3:0] round_o;
  logic       busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Scoreboard queues
  int         exp_done_q[$];
  logic [3:0] exp_ksel_q[$];

  // Handshake responder configuration
  bit key_hold = 1'b1;
  bit sbox_hold = 1'b1;
  int key_delay = 0;
  int sbox_delay = 0;
  int kwait = 0;
  int swait = 0;

  // Monitor statistics
  int n_ark, n_sub, n_shift, n_mix, n_mix10, n_sbox_cyc, n_kreq_cyc;
  int n_done = 0;
  int load_cyc, shift10_cyc, req10_cyc;
  logic       prev_req = 1'b0;
  logic [3:0] held_sel = 4'd0;
  logic [3:0] exp_sel;
  int         exp_c;

`ifdef AES_CTRL_TIMEOUT_EN
  aes_round_ctrl #(.NO_ROUNDS(10), .TIMEOUT_CYCLES(8)) dut (
`else
  aes_round_ctrl #(.NO_ROUNDS(10)) dut (
`endif
    .aes_clk      (aes_clk),
    .resetn       (resetn),
    .aes_core_en  (aes_core_en),
    .start_i      (start_i),
    .key_vld_i    (key_vld_i),
    .sbox_valid_i (sbox_valid_i),
    .key_req_o    (key_req_o),
    .key_sel_o    (key_sel_o),
    .sbox_en_o    (sbox_en_o),
    .load_en_o    (load_en_o),
    .ark_en_o     (ark_en_o),
    .sub_en_o     (sub_en_o),
    .shift_en_o   (shift_en_o),
    .mix_en_o     (mix_en_o),
    .round_o      (round_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 aes_clk = ~aes_clk;

  always @(posedge aes_clk) cyc <= cyc + 1;

  // Key store / S-box responder: answer after a configurable number of waits.
  always @(negedge aes_clk) begin
    if (key_req_o) begin
      key_vld_i = key_hold || (kwait == key_delay);
      kwait++;
    end else begin
      key_vld_i = key_hold;
      kwait = 0;
    end
    if (sbox_en_o) begin
      sbox_valid_i = sbox_hold || (swait == sbox_delay);
      swait++;
    end else begin
      sbox_valid_i = sbox_hold;
      swait = 0;
    end
  end

  // Output monitor and scoreboard consumer.
  always @(negedge aes_clk) begin
    if (ark_en_o)   n_ark++;
    if (sub_en_o)   n_sub++;
    if (shift_en_o) n_shift++;
    if (mix_en_o)   n_mix++;
    if (sbox_en_o)  n_sbox_cyc++;
    if (key_req_o)  n_kreq_cyc++;
    if (load_en_o)  load_cyc = cyc;
    if (mix_en_o && round_o == 4'd10) n_mix10++;
    if (shift_en_o && round_o == 4'd10) shift10_cyc = cyc;
    if (key_req_o && !prev_req) begin
      if (key_sel_o == 4'd10) req10_cyc = cyc;
      n_cmp++;
      if (exp_ksel_q.size() == 0) begin
        n_err++;
        $display("FAIL key_sel_order: request with key_sel=%0d, none expected", key_sel_o);
      end else begin
        exp_sel = exp_ksel_q.pop_front();
        if (key_sel_o !== exp_sel) begin
          n_err++;
          $display("FAIL key_sel_order: got %0d want %0d", key_sel_o, exp_sel);
        end
      end
      held_sel = key_sel_o;
    end else if (key_req_o) begin
      n_cmp++;
      if (key_sel_o !== held_sel) begin
        n_err++;
        $display("FAIL key_sel_stable: got %0d want %0d", key_sel_o, held_sel);
      end
    end
    prev_req = key_req_o;
    if (done_o) begin
      n_done++;
      n_cmp++;
      if (exp_done_q.size() == 0) begin
        n_err++;
        $display("FAIL done_cycle: unexpected done_o at cycle %0d", cyc);
      end else begin
        exp_c = exp_done_q.pop_front();
        if (cyc !== exp_c) begin
          n_err++;
          $display("FAIL done_cycle: got cycle %0d want %0d", cyc, exp_c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    n_ark = 0; n_sub = 0; n_shift = 0; n_mix = 0; n_mix10 = 0;
    n_sbox_cyc = 0; n_kreq_cyc = 0;
    load_cyc = -1; shift10_cyc = -1; req10_cyc = -1;
  endtask

  task automatic push_keys(input int last);
    for (int k = 0; k <= last; k++) exp_ksel_q.push_back(4'(k));
  endtask

  // Called at a negedge; c is the cycle in which start_i is sampled.
  task automatic pulse_start(output int c);
    start_i = 1'b1;
    c = cyc;
    @(negedge aes_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge aes_clk);
      if (n_done != d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    aes_core_en = 1'b0;
    repeat (3) @(negedge aes_clk);
    n_cmp++;
    if ({key_req_o, key_sel_o, sbox_en_o, load_en_o, ark_en_o, sub_en_o, shift_en_o,
         mix_en_o, round_o, busy_o, done_o, err_o} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b round=%0d req=%b done=%b want all 0",
               busy_o, round_o, key_req_o, done_o);
    end
    resetn = 1'b1;
    aes_core_en = 1'b1;
    repeat (2) @(negedge aes_clk);
    n_cmp++;
    if (busy_o !== 1'b0 || round_o !== 4'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b round=%0d want 0/0", busy_o, round_o);
    end
  endtask

  task automatic test_zero_wait();
    int c, d0;
    bit ok;
    key_hold = 1'b1; sbox_hold = 1'b1;
    clear_stats();
    d0 = n_done;
    push_keys(10);
    pulse_start(c);
    exp_done_q.push_back(c + 53);
    wait_done(d0, 120, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL zero_wait_timeout: done_o not seen, want one"); end
    repeat (3) @(negedge aes_clk);
    n_cmp++;
    if (n_ark !== 11 || n_sub !== 10 || n_shift !== 10 || n_mix !== 9) begin
      n_err++;
      $display("FAIL zero_wait_strobes: ark=%0d sub=%0d shift=%0d mix=%0d want 11/10/10/9",
               n_ark, n_sub, n_shift, n_mix);
    end
    n_cmp++;
    if (load_cyc !== c + 1) begin
      n_err++;
      $display("FAIL load_cycle: got %0d want %0d", load_cyc, c + 1);
    end
    n_cmp++;
    if (round_o !== 4'd10 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_wait_end: round=%0d busy=%b want 10/0", round_o, busy_o);
    end
    n_cmp++;
    if (exp_ksel_q.size() !== 0) begin
      n_err++;
      $display("FAIL zero_wait_keys: %0d key requests missing, want 0", exp_ksel_q.size());
    end
  endtask

  task automatic test_key_wait();
    int c, d0;
    bit ok;
    key_hold = 1'b0; key_delay = 3; sbox_hold = 1'b1;
    clear_stats();
    d0 = n_done;
    push_keys(10);
    pulse_start(c);
    exp_done_q.push_back(c + 86);
    wait_done(d0, 150, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL key_wait_timeout: done_o not seen, want one"); end
    repeat (2) @(negedge aes_clk);
    n_cmp++;
    if (n_kreq_cyc !== 44 || n_ark !== 11) begin
      n_err++;
      $display("FAIL key_wait_req_cycles: req=%0d ark=%0d want 44/11", n_kreq_cyc, n_ark);
    end
    key_hold = 1'b1; key_delay = 0;
  endtask

  task automatic test_final_round();
    int c, d0;
    bit ok;
    key_hold = 1'b1; sbox_hold = 1'b0; sbox_delay = 1;
    clear_stats();
    d0 = n_done;
    push_keys(10);
    pulse_start(c);
    exp_done_q.push_back(c + 63);
    wait_done(d0, 120, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL final_round_timeout: done_o not seen, want one"); end
    repeat (4) @(negedge aes_clk);
    n_cmp++;
    if (n_mix10 !== 0 || req10_cyc - shift10_cyc !== 1) begin
      n_err++;
      $display("FAIL final_round_no_mix: mix10=%0d gap=%0d want 0/1", n_mix10, req10_cyc - shift10_cyc);
    end
    n_cmp++;
    if (n_sbox_cyc !== 20 || n_sub !== 10) begin
      n_err++;
      $display("FAIL final_round_sbox: sbox_cyc=%0d sub=%0d want 20/10", n_sbox_cyc, n_sub);
    end
    n_cmp++;
    if (round_o !== 4'd10) begin
      n_err++;
      $display("FAIL round_hold: got %0d want 10", round_o);
    end
    sbox_hold = 1'b1; sbox_delay = 0;
  endtask

  task automatic test_abort();
    int c, d0;
    bit ok;
    key_hold = 1'b1; sbox_hold = 1'b0; sbox_delay = 2;
    clear_stats();
    d0 = n_done;
    push_keys(4);
    pulse_start(c);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (sbox_en_o && round_o == 4'd5) ok = 1'b1;
      else @(negedge aes_clk);
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL abort_reach: round 5 SUB_WAIT not seen, want it"); end
    aes_core_en = 1'b0;
    @(negedge aes_clk);
    n_cmp++;
    if ({key_req_o, key_sel_o, sbox_en_o, load_en_o, ark_en_o, sub_en_o, shift_en_o,
         mix_en_o, round_o, busy_o, done_o, err_o} !== 17'd0) begin
      n_err++;
      $display("FAIL abort_outputs: busy=%b round=%0d sbox_en=%b sub=%b want all 0",
               busy_o, round_o, sbox_en_o, sub_en_o);
    end
    repeat (5) @(negedge aes_clk);
    n_cmp++;
    if (n_done !== d0 || exp_ksel_q.size() !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: done=%0d keys_left=%0d want %0d/0", n_done, exp_ksel_q.size(), d0);
    end
    aes_core_en = 1'b1; sbox_hold = 1'b1; sbox_delay = 0;
    @(negedge aes_clk);
    push_keys(10);
    pulse_start(c);
    exp_done_q.push_back(c + 53);
    wait_done(d0, 120, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL abort_restart: done_o not seen, want one"); end
    repeat (2) @(negedge aes_clk);
  endtask

  task automatic test_start_busy();
    int c, d0;
    bit ok;
    key_hold = 1'b1; sbox_hold = 1'b1;
    d0 = n_done;
    push_keys(10);
    pulse_start(c);
    exp_done_q.push_back(c + 53);
    repeat (9) @(negedge aes_clk);
    start_i = 1'b1;
    @(negedge aes_clk);
    start_i = 1'b0;
    repeat (9) @(negedge aes_clk);
    start_i = 1'b1;
    @(negedge aes_clk);
    start_i = 1'b0;
    wait_done(d0, 120, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL busy_start_timeout: done_o not seen, want one"); end
    repeat (10) @(negedge aes_clk);
    n_cmp++;
    if (n_done - d0 !== 1 || busy_o !== 1'b0 || exp_done_q.size() !== 0) begin
      n_err++;
      $display("FAIL busy_start_single: dones=%0d busy=%b want 1/0", n_done - d0, busy_o);
    end
  endtask

`ifdef AES_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int c, d0;
    key_hold = 1'b0; key_delay = 1000;
    d0 = n_done;
    push_keys(0);
    pulse_start(c);
    repeat (8) @(negedge aes_clk);
    n_cmp++;
    if (key_req_o !== 1'b1 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_wait: req=%b err=%b want 1/0 at cycle %0d", key_req_o, err_o, cyc);
    end
    @(negedge aes_clk);
    n_cmp++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || key_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_err: err=%b busy=%b req=%b want 1/0/0", err_o, busy_o, key_req_o);
    end
    repeat (5) @(negedge aes_clk);
    n_cmp++;
    if (err_o !== 1'b1 || n_done !== d0) begin
      n_err++;
      $display("FAIL timeout_sticky: err=%b dones=%0d want 1/%0d", err_o, n_done, d0);
    end
    resetn = 1'b0;
    @(negedge aes_clk);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_reset_clear: err=%b want 0", err_o);
    end
    resetn = 1'b1;
    key_hold = 1'b1; key_delay = 0;
    @(negedge aes_clk);
  endtask
`else
  task automatic test_err_tied();
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_tied: got %b want 0", err_o);
    end
  endtask
`endif

  initial begin
    clear_stats();
    @(negedge aes_clk);
    test_reset();
    test_zero_wait();
    test_key_wait();
    test_final_round();
    test_abort();
    test_start_busy();
`ifdef AES_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
